// File: rtl/prbs_test_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | prbs_test_ctrl : sequences one PRBS link test (reset, ready, lock, measure)  |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module prbs_test_ctrl #(
    parameter int          SIZE         = 32,
    parameter int          RST_CYCLES   = 16,
    parameter int          LOCK_WORDS   = 64,
    parameter int          LOSS_WORDS   = 4,
    parameter int unsigned TEST_WORDS   = 1048576,
    parameter int          SYNC_TIMEOUT = 4096
) (
    input  logic            gtwiz_userclk_rx_usrclk2_in,
    input  logic            gtwiz_reset_all_n_in,
    input  logic            start_in,
    input  logic            abort_in,
    input  logic            rx_ready_in,
    input  logic            err_valid_in,
    input  logic [SIZE-1:0] err_in,
    output logic            gen_reset_out,
    output logic            busy_out,
    output logic            locked_out,
    output logic            done_out,
    output logic            pass_out,
    output logic            timeout_out,
    output logic [31:0]     bit_err_count_out,
    output logic [31:0]     word_count_out,
    output logic [7:0]      relock_count_out,
    output logic [2:0]      state_out
);
    localparam int c_PCW = $clog2(SIZE + 1);
    localparam int c_RCW = $clog2(RST_CYCLES + 1);
    localparam int c_LKW = $clog2(LOCK_WORDS + 1);
    localparam int c_LSW = $clog2(LOSS_WORDS + 1);
    localparam int c_TOW = $clog2(SYNC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RESET    = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_SYNC     = 3'd3,
        S_RUN      = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t           r_state, w_nxt_state;
    logic [c_RCW-1:0] r_rst_cnt, w_rst_cnt_nxt;
    logic [c_LKW-1:0] r_clean, w_clean_nxt;
    logic [c_LSW-1:0] r_loss, w_loss_nxt;
    logic [c_TOW-1:0] r_tcnt, w_tcnt_nxt;
    logic [31:0]      r_words, w_words_nxt;
    logic [31:0]      r_bit_err, w_bit_err_nxt;
    logic [7:0]       r_relock, w_relock_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             r_gen_reset, r_busy, r_locked, r_done, r_pass;
    logic [c_PCW-1:0] w_popcnt;
    logic [32:0]      w_be_sum;
    logic             w_err;
    logic             w_pass_nxt;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < SIZE; i++) begin
            w_popcnt = w_popcnt + c_PCW'(err_in[i]);
        end
    end

    assign w_err    = |err_in;
    assign w_be_sum = {1'b0, r_bit_err} + 33'(w_popcnt);

    always_comb begin
        w_nxt_state   = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        w_clean_nxt   = r_clean;
        w_loss_nxt    = r_loss;
        w_tcnt_nxt    = r_tcnt;
        w_words_nxt   = r_words;
        w_bit_err_nxt = r_bit_err;
        w_relock_nxt  = r_relock;
        w_timeout_nxt = r_timeout;
        if (abort_in) begin
            w_nxt_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_in) begin
                        w_nxt_state   = S_RESET;
                        w_rst_cnt_nxt = '0;
                        w_words_nxt   = '0;
                        w_bit_err_nxt = '0;
                        w_relock_nxt  = '0;
                        w_timeout_nxt = 1'b0;
                    end
                end
                S_RESET: begin
                    if (r_rst_cnt == c_RCW'(RST_CYCLES - 1)) begin
                        w_nxt_state = S_WAIT_RDY;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                    end
                end
                S_WAIT_RDY: begin
                    if (rx_ready_in) begin
                        w_nxt_state = S_SYNC;
                        w_clean_nxt = '0;
                        w_tcnt_nxt  = '0;
                    end
                end
                S_SYNC: begin
                    if (!rx_ready_in) begin
                        w_nxt_state = S_WAIT_RDY;
                    end else if (err_valid_in && !w_err &&
                                 r_clean == c_LKW'(LOCK_WORDS - 1)) begin
                        w_nxt_state = S_RUN;
                        w_loss_nxt  = '0;
                    end else if (r_tcnt == c_TOW'(SYNC_TIMEOUT - 1)) begin
                        w_nxt_state   = S_DONE;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                        if (err_valid_in) begin
                            w_clean_nxt = w_err ? '0 : r_clean + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (!rx_ready_in) begin
                        w_nxt_state = S_WAIT_RDY;
                    end else if (err_valid_in) begin
                        w_words_nxt   = r_words + 32'd1;
                        w_bit_err_nxt = w_be_sum[32] ? 32'hFFFF_FFFF : w_be_sum[31:0];
                        w_loss_nxt    = w_err ? r_loss + 1'b1 : '0;
                        // End of test outranks a simultaneous loss of lock.
                        if (w_words_nxt == 32'(TEST_WORDS)) begin
                            w_nxt_state = S_DONE;
                        end else if (w_err && r_loss == c_LSW'(LOSS_WORDS - 1)) begin
                            w_nxt_state  = S_SYNC;
                            w_relock_nxt = (r_relock == 8'hFF) ? r_relock : r_relock + 8'd1;
                            w_clean_nxt  = '0;
                            w_tcnt_nxt   = '0;
                        end
                    end
                end
                default: w_nxt_state = S_IDLE;
            endcase
        end
    end

    assign w_pass_nxt = !w_timeout_nxt && (w_bit_err_nxt == 32'd0) && (w_relock_nxt == 8'd0);

    always_ff @(posedge gtwiz_userclk_rx_usrclk2_in or negedge gtwiz_reset_all_n_in) begin
        if (!gtwiz_reset_all_n_in) begin
            r_state     <= S_IDLE;
            r_rst_cnt   <= '0;
            r_clean     <= '0;
            r_loss      <= '0;
            r_tcnt      <= '0;
            r_words     <= '0;
            r_bit_err   <= '0;
            r_relock    <= '0;
            r_timeout   <= 1'b0;
            r_gen_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_locked    <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_rst_cnt   <= w_rst_cnt_nxt;
            r_clean     <= w_clean_nxt;
            r_loss      <= w_loss_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_words     <= w_words_nxt;
            r_bit_err   <= w_bit_err_nxt;
            r_relock    <= w_relock_nxt;
            r_timeout   <= w_timeout_nxt;
            r_gen_reset <= (w_nxt_state == S_IDLE) || (w_nxt_state == S_RESET);
            r_busy      <= (w_nxt_state == S_RESET) || (w_nxt_state == S_WAIT_RDY) ||
                           (w_nxt_state == S_SYNC)  || (w_nxt_state == S_RUN);
            r_locked    <= (w_nxt_state == S_RUN);
            r_done      <= (w_nxt_state == S_DONE);
            // Pass verdict is captured once, on the edge that enters DONE.
            if (w_nxt_state != S_DONE) begin
                r_pass <= 1'b0;
            end else if (r_state != S_DONE) begin
                r_pass <= w_pass_nxt;
            end
        end
    end

    assign gen_reset_out     = r_gen_reset;
    assign busy_out          = r_busy;
    assign locked_out        = r_locked;
    assign done_out          = r_done;
    assign pass_out          = r_pass;
    assign timeout_out       = r_timeout;
    assign bit_err_count_out = r_bit_err;
    assign word_count_out    = r_words;
    assign relock_count_out  = r_relock;
    assign state_out         = r_state;

endmodule
`default_nettype wire
